// File: rtl/tt_um_uio_responder.sv
// tt_um_uio_responder: Tiny Tapeout top that exposes an 8x8 register file to an
// external host over the uio bus using a strobe/ack handshake.
//   ui_in[7] strobe, ui_in[6] rw (1=read), ui_in[2:0] address, uio_in write data.
//   uo_out = {ack, busy, timeout, wr_cnt[4:0]}; uio_oe/uio_out driven only in ACK_RD.
//   Address 7 reads back (reg0 + reg1) mod 256 and ignores writes.
// Optional feature: define UIO_TIMEOUT_EN to bound the read-hold time to
// TIMEOUT_CYCLES clocks, with a sticky timeout flag on uo_out[5].
module tt_um_uio_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {IDLE, ACK_WR, ACK_RD, TURN} state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   rise_ok;
  logic                   timeout_hit;
  logic                   timeout_flag;
  logic                   ack_q;
  logic                   busy_q;
  logic [7:0]             oe_q;
  logic [7:0]             dout_q;
  logic [4:0]             wr_cnt;
  logic [7:0]             regs [8];
  logic [7:0]             sum;
  logic [7:0]             rd_value;
  logic                   rw;
  logic [2:0]             addr;
  logic                   unused_inputs;

  assign rw   = ui_in[6];
  assign addr = ui_in[2:0];

  // Strobe synchroniser plus one-cycle delay for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      s_d     <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], ui_in[7]};
      s_d     <= s;
    end
  end

  assign s    = sync_p0[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  // Address 7 is a derived read-only value, wrapping mod 256
  assign sum      = regs[0] + regs[1];
  assign rd_value = (addr == 3'd7) ? sum : regs[addr];

`ifdef UIO_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        need_low;

  assign timeout_hit = (state == ACK_RD) && s && (to_cnt == TIMEOUT_W - 16'd1);
  assign rise_ok     = rise & ~need_low;

  // Read-hold counter, sticky timeout flag and re-arm on strobe low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt       <= 16'd0;
      timeout_flag <= 1'b0;
      need_low     <= 1'b0;
    end else begin
      if ((state == ACK_RD) && s && !timeout_hit) begin
        to_cnt <= to_cnt + 16'd1;
      end else begin
        to_cnt <= 16'd0;
      end
      if (timeout_hit) begin
        timeout_flag <= 1'b1;
        need_low     <= 1'b1;
      end else if (!s) begin
        need_low <= 1'b0;
      end
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
  assign rise_ok      = rise;
`endif

  // Handshake FSM with registered bus outputs, register file and write counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
      oe_q   <= 8'h00;
      dout_q <= 8'h00;
      wr_cnt <= 5'd0;
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      case (state)
        IDLE: begin
          if (rise_ok) begin
            ack_q  <= 1'b1;
            busy_q <= 1'b1;
            if (rw) begin
              state  <= ACK_RD;
              oe_q   <= 8'hFF;
              dout_q <= rd_value;
            end else begin
              state  <= ACK_WR;
              wr_cnt <= wr_cnt + 5'd1;
              if (addr != 3'd7) begin
                regs[addr] <= uio_in;
              end
            end
          end
        end
        ACK_WR: begin
          if (!s) begin
            state  <= IDLE;
            ack_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        ACK_RD: begin
          if (!s || timeout_hit) begin
            state  <= TURN;
            ack_q  <= 1'b0;
            oe_q   <= 8'h00;
            dout_q <= 8'h00;
          end
        end
        TURN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          ack_q  <= 1'b0;
          busy_q <= 1'b0;
          oe_q   <= 8'h00;
          dout_q <= 8'h00;
        end
      endcase
    end
  end

  assign uio_oe  = oe_q;
  assign uio_out = dout_q;
  assign uo_out  = {ack_q, busy_q, timeout_flag, wr_cnt};

  assign unused_inputs = &{1'b0, ena, ui_in[5:3], (TIMEOUT_W == 16'd0)};

endmodule

// File: tb/tb_tt_um_uio_responder.sv
// Directed bench for tt_um_uio_responder: reset, write/readback, sum register,
// snapshot hold, short strobe, long hold (or timeout when UIO_TIMEOUT_EN),
// asynchronous reset during a read, and write-counter wrap.
module tb_tt_um_uio_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int checks = 0;
  int errors = 0;
  int busy_err = 0;

  always #5 clk = ~clk;

  tt_um_uio_responder #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .ui_in(ui_in),
    .uio_in(uio_in),
    .uio_out(uio_out),
    .uio_oe(uio_oe),
    .uo_out(uo_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag, input logic lvl, output int n);
    n = 0;
    while (uo_out[7] !== lvl && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(uo_out[7]), 32'(lvl));
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    int n;
    ui_in  = {2'b00, 3'b000, a};
    uio_in = d;
    tick();
    ui_in[7] = 1'b1;
    wait_ack("wr_ack_hi", 1'b1, n);
    if (uo_out[6] !== 1'b1) busy_err++;
    ui_in[7] = 1'b0;
    wait_ack("wr_ack_lo", 1'b0, n);
    if (uo_out[6] !== 1'b0) busy_err++;
  endtask

  task automatic start_read(input logic [2:0] a, output logic [7:0] d, output int lat);
    ui_in = {2'b01, 3'b000, a};
    tick();
    ui_in[7] = 1'b1;
    wait_ack("rd_ack_hi", 1'b1, lat);
    d = uio_out;
    check("rd_oe_on", 32'(uio_oe), 32'hFF);
  endtask

  task automatic end_read();
    int n;
    ui_in[7] = 1'b0;
    wait_ack("rd_ack_lo", 1'b0, n);
    check("rd_fall_lat", 32'(n), 3);
    check("turn_oe", 32'(uio_oe), 32'h00);
    check("turn_dout", 32'(uio_out), 32'h00);
    check("turn_busy", 32'(uo_out[6]), 1);
    tick();
    check("idle_busy", 32'(uo_out[6]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int lat;
    int mism;
    int acks;
    int k;

    // reset state, asynchronous (no clock edge yet)
    #1;
    check("rst_oe", 32'(uio_oe), 32'h00);
    check("rst_dout", 32'(uio_out), 32'h00);
    check("rst_uo", 32'(uo_out), 32'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // write / readback
    do_write(3'd2, 8'h3C);
    check("wrcnt_1", 32'(uo_out[4:0]), 1);
    start_read(3'd2, d, lat);
    check("rd2_lat", 32'(lat), 3);
    check("rd2_data", 32'(d), 32'h3C);
    end_read();
    check("wrcnt_after_rd", 32'(uo_out[4:0]), 1);

    // sum register and dropped write to addr 7
    do_write(3'd0, 8'hF0);
    do_write(3'd1, 8'h20);
    start_read(3'd7, d, lat);
    check("sum_f0_20", 32'(d), 32'h10);
    end_read();
    do_write(3'd7, 8'h55);
    check("wrcnt_addr7", 32'(uo_out[4:0]), 4);
    start_read(3'd7, d, lat);
    check("sum_after_wr7", 32'(d), 32'h10);
    end_read();

    // snapshot hold; rw/addr/data changes during ACK_RD are ignored
    start_read(3'd0, d, lat);
    check("snap_first", 32'(d), 32'hF0);
    ui_in[6:0] = 7'b0000001;
    uio_in = 8'hAA;
    mism = 0;
    repeat (5) begin
      tick();
      if (uio_out !== 8'hF0 || uio_oe !== 8'hFF || uo_out[7] !== 1'b1) mism++;
    end
    check("snap_hold", 32'(mism), 0);
    end_read();
    check("snap_no_write_cnt", 32'(uo_out[4:0]), 4);
    start_read(3'd0, d, lat);
    check("snap_reg0", 32'(d), 32'hF0);
    end_read();
    start_read(3'd1, d, lat);
    check("snap_reg1", 32'(d), 32'h20);
    end_read();

    // sum wraps mod 256
    do_write(3'd0, 8'hFF);
    do_write(3'd1, 8'h01);
    start_read(3'd7, d, lat);
    check("sum_wrap", 32'(d), 32'h00);
    end_read();

    // strobe pulse entirely between clock edges is never seen
    ui_in  = {2'b00, 3'b000, 3'd3};
    uio_in = 8'h77;
    tick();
    ui_in[7] = 1'b1;
    #3;
    ui_in[7] = 1'b0;
    acks = 0;
    repeat (10) begin
      tick();
      if (uo_out[7] !== 1'b0) acks++;
    end
    check("short_no_ack", 32'(acks), 0);
    check("short_wrcnt", 32'(uo_out[4:0]), 6);
    start_read(3'd3, d, lat);
    check("short_reg3", 32'(d), 32'h00);
    end_read();

`ifdef UIO_TIMEOUT_EN
    // read held 50 cycles: released after 10, flag sticky, no re-ack while held
    start_read(3'd2, d, lat);
    check("to_data", 32'(d), 32'h3C);
    k = 0;
    while (uio_oe === 8'hFF && k < 60) begin
      tick();
      k++;
    end
    check("to_release_cycles", 32'(k), 10);
    check("to_flag", 32'(uo_out[5]), 1);
    check("to_ack_low", 32'(uo_out[7]), 0);
    acks = 0;
    repeat (40) begin
      tick();
      if (uo_out[7] !== 1'b0) acks++;
    end
    check("to_no_reack", 32'(acks), 0);
    ui_in[7] = 1'b0;
    repeat (4) tick();
    start_read(3'd2, d, lat);
    check("to_reread", 32'(d), 32'h3C);
    end_read();
    check("to_flag_sticky", 32'(uo_out[5]), 1);
`else
    // read held 50 cycles: bus stays driven, no timeout flag
    start_read(3'd2, d, lat);
    mism = 0;
    repeat (50) begin
      tick();
      if (uio_oe !== 8'hFF || uio_out !== 8'h3C || uo_out[7] !== 1'b1 || uo_out[5] !== 1'b0) mism++;
    end
    check("hold50", 32'(mism), 0);
    end_read();
`endif

    // asynchronous reset while driving read data
    start_read(3'd2, d, lat);
    check("pre_rst_oe", 32'(uio_oe), 32'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe", 32'(uio_oe), 32'h00);
    check("rst_mid_dout", 32'(uio_out), 32'h00);
    check("rst_mid_uo", 32'(uo_out), 32'h00);
    ui_in = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    start_read(3'd2, d, lat);
    check("rst_regs_clear", 32'(d), 32'h00);
    end_read();
    check("rst_wrcnt", 32'(uo_out[4:0]), 0);

    // write counter wraps 31 -> 0 -> 1
    for (int i = 1; i <= 33; i++) begin
      do_write(3'(i % 7), 8'(i));
      if (i == 31) check("wrcnt_31", 32'(uo_out[4:0]), 31);
      if (i == 32) check("wrcnt_wrap0", 32'(uo_out[4:0]), 0);
    end
    check("wrcnt_33", 32'(uo_out[4:0]), 1);
    check("busy_track", 32'(busy_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
